// File: rtl/tick_gen_if.sv
// rtl/tick_gen_if.sv - divided-clock inputs, source select and tick/status outputs of tick_gen
interface tick_gen_if #(
  parameter int CNT_W = 16
);
  logic             clk_div2_i;
  logic             clk_div4_i;
  logic             clk_div8_i;
  logic             clk_div16_i;
  logic [1:0]       sel_i;
  logic             en_i;
  logic             tick_o;
  logic [CNT_W-1:0] tick_cnt_o;
  logic             locked_o;
  logic             stall_o;

  modport master (
    output clk_div2_i, clk_div4_i, clk_div8_i, clk_div16_i, sel_i, en_i,
    input  tick_o, tick_cnt_o, locked_o, stall_o
  );

  modport slave (
    input  clk_div2_i, clk_div4_i, clk_div8_i, clk_div16_i, sel_i, en_i,
    output tick_o, tick_cnt_o, locked_o, stall_o
  );
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - resynchronises a selected divided clock into clk_i and emits one-cycle ticks
// Stall detection (gap counter + STALL state) is built only when TICK_GEN_STALL_DET_EN is defined.
module tick_gen #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 16,
  parameter int STALL_CYCLES = 64
) (
  input logic       clk_i,
  input logic       rstn_i,
  tick_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
`ifdef TICK_GEN_STALL_DET_EN
    S_STALL,
`endif
    S_RUN
  } state_t;

  // Out-of-range parameters elaborate into a visibly named scope.
  if (SYNC_STAGES < 2 || STALL_CYCLES < 2) begin : g_illegal_parameter_value
  end

  logic [3:0]             w_async;
  logic [SYNC_STAGES-1:0] r_sync [4];
  logic [1:0]             r_sel_q;
  logic                   r_mux;
  logic                   r_prev;
  logic                   w_rise;
  logic                   w_sel_chg;

  state_t                 r_state;
  logic                   r_tick;
  logic [CNT_W-1:0]       r_tick_cnt;
  logic                   r_locked;

`ifdef TICK_GEN_STALL_DET_EN
  localparam int GAP_W = $clog2(STALL_CYCLES + 1);
  logic [GAP_W-1:0]       r_gap;
  logic                   r_stall;
`endif

  assign w_async = {bus.clk_div16_i, bus.clk_div8_i, bus.clk_div4_i, bus.clk_div2_i};

  // The mux output is registered so a select change never glitches into the edge detector.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 4; i++) r_sync[i] <= '0;
      r_sel_q <= 2'd0;
      r_mux   <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_async[i]};
      r_sel_q <= bus.sel_i;
      r_mux   <= r_sync[r_sel_q][SYNC_STAGES-1];
      r_prev  <= r_mux;
    end
  end

  assign w_rise    = r_mux & ~r_prev;
  assign w_sel_chg = (bus.sel_i != r_sel_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_tick     <= 1'b0;
      r_tick_cnt <= '0;
      r_locked   <= 1'b0;
`ifdef TICK_GEN_STALL_DET_EN
      r_gap      <= '0;
      r_stall    <= 1'b0;
`endif
    end else begin
      r_tick <= 1'b0;
`ifdef TICK_GEN_STALL_DET_EN
      r_gap  <= '0;
`endif
      if (!bus.en_i) begin
        r_state    <= S_IDLE;
        r_tick_cnt <= '0;
        r_locked   <= 1'b0;
`ifdef TICK_GEN_STALL_DET_EN
        r_stall    <= 1'b0;
`endif
      end else if (r_state != S_IDLE && w_sel_chg) begin
        r_state  <= S_ARM;
        r_locked <= 1'b0;
`ifdef TICK_GEN_STALL_DET_EN
        r_stall  <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state    <= S_ARM;
            r_tick_cnt <= '0;
          end
          // The first rise after arming only proves the new source is alive.
          S_ARM: begin
            if (w_rise) begin
              r_state  <= S_RUN;
              r_locked <= 1'b1;
            end
          end
          S_RUN: begin
            if (w_rise) begin
              r_tick     <= 1'b1;
              r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
`ifdef TICK_GEN_STALL_DET_EN
            else if (r_gap == GAP_W'(STALL_CYCLES - 1)) begin
              r_state  <= S_STALL;
              r_locked <= 1'b0;
              r_stall  <= 1'b1;
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
`endif
          end
`ifdef TICK_GEN_STALL_DET_EN
          S_STALL: begin
            if (w_rise) begin
              r_state    <= S_RUN;
              r_locked   <= 1'b1;
              r_stall    <= 1'b0;
              r_tick     <= 1'b1;
              r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tick_o     = r_tick;
  assign bus.tick_cnt_o = r_tick_cnt;
  assign bus.locked_o   = r_locked;
`ifdef TICK_GEN_STALL_DET_EN
  assign bus.stall_o    = r_stall;
`else
  assign bus.stall_o    = 1'b0;
`endif

endmodule
